// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider math.
// Used by both the RX path and the TX-side baud clock generation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int DEFAULT_OVERSAMPLE = 16;

    // System clocks per oversample tick, truncated toward zero.
    function automatic int clks_per_tick(
        input int clk_hz,
        input int baud,
        input int os
    );
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one-clk pulse every CLK_DIV clocks.
// Synchronous clear pins the phase to the detected start edge.
module uart_tick_gen #(
    parameter int CLK_DIV = 325
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (i_clr || r_div_cnt == LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + W'(1);
        end
    end

    assign o_tick = (r_div_cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled 8N1 UART receiver with start-glitch rejection,
// framing-error detection and break handling.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = clks_per_tick(50_000_000, 9600, DEFAULT_OVERSAMPLE),
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic [1:0]           r_sync;
    uart_state_e          r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;

    logic w_rx_s;
    logic w_tick;
    logic w_div_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx_s    = r_sync[1];
    assign w_div_clr = (r_state == IDLE);

    uart_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_div_clr),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (!w_rx_s) r_state <= START;
                end
                START: if (w_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        // From here on every sample lands mid-bit.
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
                DATA: if (w_tick) begin
                    if (r_tick_cnt == TICK_END) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt  <= r_bit_cnt + BW'(1);
                        if (r_bit_cnt == BIT_LAST) r_state <= STOP;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
                STOP: if (w_tick) begin
                    if (r_tick_cnt == TICK_END) begin
                        r_tick_cnt <= '0;
                        if (w_rx_s) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
                BREAK: if (w_rx_s) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scenario bench for uart_rx_oversampled at CLK_DIV=4, OVERSAMPLE=16
// (64 clks per bit), with a byte scoreboard and a pulse-rule monitor.
module tb_uart_rx_oversampled;

    localparam int CLK_DIV = 4;
    localparam int OS      = 16;
    localparam int DB      = 8;
    localparam int BCLK    = CLK_DIV * OS;
    localparam int PERIOD  = 10;
    localparam int LAT     = (OS / 2 + OS * (DB + 1)) * CLK_DIV + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    int n_checks = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_viol = 0;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;

    logic [DB-1:0] exp_q[$];

    uart_rx_oversampled #(
        .CLK_DIV(CLK_DIV),
        .OVERSAMPLE(OS),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #(PERIOD / 2) clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (frame_err) n_ferr++;
        if ((rx_valid && frame_err) || (rx_valid && prev_v) || (frame_err && prev_f))
            n_viol++;
        prev_v = rx_valid;
        prev_f = frame_err;
    end

    // Called on a negedge; returns on the negedge ending the stop bit.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int bclk);
        rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (bclk) @(negedge clk);
        end
        rx = stop;
        repeat (bclk) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output logic got,
                              output logic [DB-1:0] d, output longint t);
        got = 1'b0;
        d = '0;
        t = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                got = 1'b1;
                d = rx_data;
                t = $time;
            end
        end
    endtask

    // Drive one frame from the current negedge and collect the rx_valid pulse.
    task automatic send_collect(input logic [7:0] d, input int bclk, output logic got,
                                output logic [DB-1:0] q, output int lat);
        longint t0, t1;
        @(negedge clk);
        t0 = $time;
        fork
            drive_frame(d, 1'b1, bclk);
            wait_valid(LAT + 40, got, q, t1);
        join
        lat = int'((t1 - t0) / PERIOD);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data);
        else n_pass++;
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid);
        else n_pass++;
        n_checks++;
        if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else n_pass++;
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame;
        logic got;
        logic [DB-1:0] q, e;
        int lat, f0;
        f0 = n_ferr;
        exp_q.push_back(8'hA5);
        send_collect(8'hA5, BCLK, got, q, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL good_timeout no rx_valid want data %h", e);
        else if (q !== e) $display("FAIL good_data got %h want %h", q, e);
        else n_pass++;
        n_checks++;
        if (lat < LAT - 1 || lat > LAT + 1)
            $display("FAIL good_latency got %0d want %0d+/-1", lat, LAT);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (n_ferr !== f0) $display("FAIL good_ferr got %0d pulses want 0", n_ferr - f0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h55};
        logic got[3];
        logic [DB-1:0] q[3];
        longint t;
        logic [DB-1:0] e;
        @(negedge clk);
        foreach (bytes[i]) exp_q.push_back(bytes[i]);
        fork
            foreach (bytes[i]) drive_frame(bytes[i], 1'b1, BCLK);
            for (int i = 0; i < 3; i++) wait_valid(LAT + 40, got[i], q[i], t);
        join
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (!got[i]) $display("FAIL b2b_timeout frame %0d no rx_valid want %h", i, e);
            else if (q[i] !== e) $display("FAIL b2b_data frame %0d got %h want %h", i, q[i], e);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_queue got %0d left want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_start_glitch;
        int last_busy, v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        last_busy = 0;
        @(negedge clk);
        rx = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 20) rx = 1'b1;
            if (busy) last_busy = i;
        end
        // Sync delay plus OS/2 ticks of start-bit qualification.
        n_checks++;
        if (last_busy == 0 || last_busy > 36)
            $display("FAIL glitch_busy last high at clk %0d want 1..36", last_busy);
        else n_pass++;
        repeat (LAT) @(negedge clk);
        n_checks++;
        if (n_valid != v0 || n_ferr != f0)
            $display("FAIL glitch_pulses got valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0);
        else n_pass++;
    endtask

    task automatic test_framing_error;
        logic got;
        logic [DB-1:0] q, e;
        int lat, v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        @(negedge clk);
        drive_frame(8'h3C, 1'b0, BCLK);
        repeat (20 * BCLK) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL ferr_busy_held got %b want 1", busy);
        else n_pass++;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ferr_busy_release got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (n_ferr - f0 != 1) $display("FAIL ferr_count got %0d want 1", n_ferr - f0);
        else n_pass++;
        n_checks++;
        if (n_valid != v0) $display("FAIL ferr_valid got %0d pulses want 0", n_valid - v0);
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'h55) $display("FAIL ferr_rx_data got %h want 55", rx_data);
        else n_pass++;
        repeat (BCLK) @(negedge clk);
        exp_q.push_back(8'h81);
        send_collect(8'h81, BCLK, got, q, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL ferr_next_timeout no rx_valid want %h", e);
        else if (q !== e) $display("FAIL ferr_next_data got %h want %h", q, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic got;
        logic [DB-1:0] q, e;
        int lat, v0;
        v0 = n_valid;
        @(negedge clk);
        fork
            drive_frame(8'hC3, 1'b1, BCLK);
            begin
                repeat (5 * BCLK + BCLK / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                n_checks++;
                if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
                    $display("FAIL midreset_outputs got data %h v %b fe %b busy %b want all 0",
                             rx_data, rx_valid, frame_err, busy);
                else n_pass++;
            end
        join
        @(negedge clk);
        reset = 1'b0;
        repeat (BCLK) @(negedge clk);
        n_checks++;
        if (n_valid != v0) $display("FAIL midreset_pulse got %0d want 0", n_valid - v0);
        else n_pass++;
        exp_q.push_back(8'h7E);
        send_collect(8'h7E, BCLK, got, q, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL midreset_next_timeout no rx_valid want %h", e);
        else if (q !== e) $display("FAIL midreset_next_data got %h want %h", q, e);
        else n_pass++;
    endtask

    task automatic test_baud_tolerance;
        int bt[2] = '{66, 62};
        logic got;
        logic [DB-1:0] q, e;
        int lat;
        for (int k = 0; k < 2; k++) begin
            repeat (BCLK) @(negedge clk);
            exp_q.push_back(8'h96);
            send_collect(8'h96, bt[k], got, q, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!got) $display("FAIL baud_timeout bit %0d clks no rx_valid want %h", bt[k], e);
            else if (q !== e) $display("FAIL baud_data bit %0d clks got %h want %h", bt[k], q, e);
            else n_pass++;
        end
    endtask

    task automatic test_pulse_rules;
        repeat (BCLK) @(negedge clk);
        n_checks++;
        if (n_viol != 0) $display("FAIL pulse_rules got %0d violations want 0", n_viol);
        else n_pass++;
        n_checks++;
        if (n_valid != 8) $display("FAIL total_valid got %0d want 8", n_valid);
        else n_pass++;
        n_checks++;
        if (n_ferr != 1) $display("FAIL total_ferr got %0d want 1", n_ferr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_start_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_baud_tolerance();
        test_pulse_rules();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
